// File: rtl/clk_div_monitor.sv
// Observes a slow divided clock from the fast clock domain: measures period and high time,
// qualifies them against expected values, and reports lock state plus a sticky fault with event count.
module clk_div_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int EXP_HIGH   = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clear,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [7:0]       fault_count
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]  EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  EXP_HIGH_C   = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0]  TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_LAST    = GOOD_W'(LOCK_COUNT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic              s1_q, s2_q, prev_q;
    logic [CNT_W-1:0]  c_q, c_d;
    logic [CNT_W-1:0]  h_q, h_d;
    logic              hv_q, hv_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [1:0]        state_q, state_d;
    logic              rise_q, fall_q;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_time_q, high_time_d;
    logic              pv_q, pv_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic [7:0]        fault_count_q, fault_count_d;

    logic rise, fall, measure, good_period, timeout, fault_event;

    // The first rise after IDLE only starts the measurement; only later rises close a period.
    assign rise        = s2_q & ~prev_q;
    assign fall        = ~s2_q & prev_q;
    assign measure     = rise && (state_q != ST_IDLE);
    assign good_period = (c_q == EXP_PERIOD_C) && hv_q && (high_time_q == EXP_HIGH_C);
    assign timeout     = (c_q == TIMEOUT_C) && !rise;
    assign fault_event = (measure && !good_period) || timeout;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        c_d           = c_q;
        h_d           = h_q;
        hv_d          = hv_q;
        good_d        = good_q;
        state_d       = state_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        pv_d          = 1'b0;
        fault_d       = fault_q;
        fault_count_d = fault_count_q;

        if (rise)                c_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (timeout)        c_d = '0;
        else if (c_q != CNT_MAX) c_d = c_q + 1'b1;

        if (rise)                         h_d = {{(CNT_W-1){1'b0}}, 1'b1};
        else if (s2_q && h_q != CNT_MAX)  h_d = h_q + 1'b1;

        if (fall) begin
            high_time_d = h_q;
            hv_d        = 1'b1;
        end
        if (rise) hv_d = 1'b0;

        if (measure) begin
            period_d = c_q;
            pv_d     = 1'b1;
        end

        if (timeout) begin
            state_d = ST_IDLE;
            good_d  = '0;
        end else if (rise) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                    good_d  = '0;
                end
                ST_ACQ: begin
                    if (good_period) begin
                        good_d = good_q + 1'b1;
                        if (good_q == LOCK_LAST) state_d = ST_LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!good_period) begin
                        state_d = ST_ACQ;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    good_d  = '0;
                end
            endcase
        end

        // A fault event in the same cycle as clear wins and restarts the count at one.
        if (fault_event) begin
            fault_d = 1'b1;
            if (clear)                      fault_count_d = 8'd1;
            else if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
        end else if (clear) begin
            fault_d       = 1'b0;
            fault_count_d = 8'd0;
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            prev_q        <= 1'b0;
            c_q           <= '0;
            h_q           <= '0;
            hv_q          <= 1'b0;
            good_q        <= '0;
            state_q       <= ST_IDLE;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            period_q      <= '0;
            high_time_q   <= '0;
            pv_q          <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_count_q <= 8'd0;
        end else begin
            s1_q          <= clk_in;
            s2_q          <= s1_q;
            prev_q        <= s2_q;
            c_q           <= c_d;
            h_q           <= h_d;
            hv_q          <= hv_d;
            good_q        <= good_d;
            state_q       <= state_d;
            rise_q        <= rise;
            fall_q        <= fall;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            pv_q          <= pv_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign fault_count  = fault_count_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: nominal lock, stuck-low timeout, duty error,
// period glitch, clear collision and asynchronous reset, with hand-computed expectations.
module tb_clk_div_monitor;

    logic       clk;
    logic       rst_n;
    logic       clk_in;
    logic       clear;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       period_valid;
    logic       locked;
    logic       fault;
    logic [7:0] fault_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int pv_cnt   = 0;
    int pv_base;

    clk_div_monitor #(
        .EXP_PERIOD(4),
        .EXP_HIGH  (2),
        .LOCK_COUNT(4),
        .TIMEOUT   (16),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_in      (clk_in),
        .clear       (clear),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rise_pulse === 1'b1)   rise_cnt++;
        if (fall_pulse === 1'b1)   fall_cnt++;
        if (period_valid === 1'b1) pv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One system-clock step: the value driven here is sampled at the next posedge.
    task automatic cyc(input logic v, input logic clr);
        clk_in = v;
        clear  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int hi, input int lo, input int clr_step);
        for (int i = 0; i < hi + lo; i++) cyc((i < hi) ? 1'b1 : 1'b0, (i == clr_step) ? 1'b1 : 1'b0);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"},   32'(rise_pulse),   0);
        check({tag, "_fall"},   32'(fall_pulse),   0);
        check({tag, "_period"}, 32'(period),       0);
        check({tag, "_high"},   32'(high_time),    0);
        check({tag, "_pv"},     32'(period_valid), 0);
        check({tag, "_locked"}, 32'(locked),       0);
        check({tag, "_fault"},  32'(fault),        0);
        check({tag, "_fcnt"},   32'(fault_count),  0);
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_in = 1'b0;
        clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal: first period stepped by hand to pin the rise_pulse latency.
        cyc(1'b1, 1'b0);
        check("rise_lat_k",  32'(rise_pulse), 0);
        cyc(1'b1, 1'b0);
        check("rise_lat_k1", 32'(rise_pulse), 0);
        cyc(1'b0, 1'b0);
        check("rise_lat_k2", 32'(rise_pulse), 1);
        check("first_pv",    32'(period_valid), 0);
        cyc(1'b0, 1'b0);
        check("rise_lat_k3", 32'(rise_pulse), 0);

        for (int j = 2; j <= 10; j++) begin
            send(2, 2, -1);
            check($sformatf("nom_period_%0d", j), 32'(period),      4);
            check($sformatf("nom_high_%0d", j),   32'(high_time),   2);
            check($sformatf("nom_locked_%0d", j), 32'(locked),      (j >= 5) ? 1 : 0);
            check($sformatf("nom_fault_%0d", j),  32'(fault),       0);
            check($sformatf("nom_fcnt_%0d", j),   32'(fault_count), 0);
        end
        check("nom_rise_cnt", 32'(rise_cnt), 10);
        check("nom_pv_cnt",   32'(pv_cnt),   9);
        check("nom_fall_cnt", 32'(fall_cnt), 9);

        // Stuck low: last rise_pulse edge was one step ago; timeout lands 16 edges after it.
        repeat (14) cyc(1'b0, 1'b0);
        check("stuck_pre_locked", 32'(locked), 1);
        check("stuck_pre_fault",  32'(fault),  0);
        cyc(1'b0, 1'b0);
        check("stuck_locked", 32'(locked),      0);
        check("stuck_fault",  32'(fault),       1);
        check("stuck_fcnt1",  32'(fault_count), 1);
        repeat (15) cyc(1'b0, 1'b0);
        check("stuck_fcnt_hold", 32'(fault_count), 1);
        repeat (3) cyc(1'b0, 1'b0);
        check("stuck_fcnt2", 32'(fault_count), 2);
        cyc(1'b0, 1'b1);
        clear = 1'b0;
        check("clear1_fault", 32'(fault),       0);
        check("clear1_fcnt",  32'(fault_count), 0);

        // Duty error 1110: each measured rise is a fault event.
        for (int j = 1; j <= 4; j++) begin
            send(3, 1, -1);
            check($sformatf("duty_fcnt_%0d", j),   32'(fault_count), j - 1);
            check($sformatf("duty_locked_%0d", j), 32'(locked),      0);
        end
        check("duty_high",   32'(high_time), 3);
        check("duty_period", 32'(period),    4);
        check("duty_fault",  32'(fault),     1);

        // Clear in the same cycle as a bad-period rise: the event wins.
        send(3, 1, 2);
        check("coll_fault", 32'(fault),       1);
        check("coll_fcnt",  32'(fault_count), 1);
        cyc(1'b0, 1'b1);
        clear = 1'b0;
        check("clear2_fault", 32'(fault),       0);
        check("clear2_fcnt",  32'(fault_count), 0);

        // Relock: first rise measures a stretched 5-cycle period, then five good ones.
        repeat (6) send(2, 2, -1);
        check("relock_locked", 32'(locked),      1);
        check("relock_fcnt",   32'(fault_count), 1);
        send(2, 2, 0);
        check("clear3_fault",  32'(fault),       0);
        check("clear3_fcnt",   32'(fault_count), 0);
        check("clear3_locked", 32'(locked),      1);

        // Period glitch: one 5-cycle period.
        send(2, 3, -1);
        check("glitch_pre_locked", 32'(locked), 1);
        send(2, 2, -1);
        check("glitch_period", 32'(period),      5);
        check("glitch_locked", 32'(locked),      0);
        check("glitch_fault",  32'(fault),       1);
        check("glitch_fcnt",   32'(fault_count), 1);
        repeat (3) send(2, 2, -1);
        check("glitch_rec3_locked", 32'(locked), 0);
        send(2, 2, -1);
        check("glitch_rec4_locked", 32'(locked), 1);
        check("glitch_rec_period",  32'(period), 4);

        // Async reset mid-high-phase while locked.
        cyc(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        clk_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pv_base = pv_cnt;
        repeat (4) send(2, 2, -1);
        check("post_rst4_locked", 32'(locked), 0);
        send(2, 2, -1);
        check("post_rst5_locked", 32'(locked), 1);
        check("post_rst_pv",      32'(pv_cnt - pv_base), 4);
        check("post_rst_period",  32'(period), 4);
        check("post_rst_fault",   32'(fault),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
